// File: rtl/instr_pkg.sv
// Shared constants, field positions and FSM encoding for the instruction encoder.
// The optional load-use hazard logic is enabled with the LOAD_USE_STALL_EN macro.
package instr_pkg;

  localparam logic [7:0]  OP_RTYPE = 8'h00;
  localparam logic [7:0]  OP_LW    = 8'h23;
  localparam logic [7:0]  OP_SW    = 8'h2B;
  localparam logic [7:0]  OP_NOP   = 8'hFF;
  localparam logic [31:0] NOP_WORD = {OP_NOP, 24'h0};

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 24;
  localparam int RS_MSB = 23;
  localparam int RS_LSB = 16;
  localparam int RT_MSB = 15;
  localparam int RT_LSB = 8;
  localparam int RD_MSB = 7;
  localparam int RD_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_BUBBLE = 2'd2
  } state_t;

  function automatic logic [31:0] packWord(input logic [7:0] op, input logic [7:0] rs,
                                           input logic [7:0] rt, input logic [7:0] rdImm);
    return {op, rs, rt, rdImm};
  endfunction

  // LW only reads its base register; rt is its destination, not a source.
  function automatic logic readsReg(input logic [31:0] word, input logic [7:0] reg_);
    logic [7:0] op;
    logic       hit;
    op  = word[OP_MSB:OP_LSB];
    hit = 1'b0;
    if (op == OP_RTYPE || op == OP_SW)
      hit = (word[RS_MSB:RS_LSB] == reg_) || (word[RT_MSB:RT_LSB] == reg_);
    else if (op == OP_LW)
      hit = (word[RS_MSB:RS_LSB] == reg_);
    return hit;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Small synchronous FIFO holding packed instruction words; head is read combinationally.
// DEPTH must be a power of two so the pointers wrap for free.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_almostEmpty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_full        = (r_count == (AW+1)'(DEPTH));
  assign o_empty       = (r_count == '0);
  assign o_almostEmpty = (r_count == (AW+1)'(1));
  assign o_rdata       = r_mem[r_rdPtr];

  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_doPush)
      r_mem[r_wrPtr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush)
        r_wrPtr <= r_wrPtr + AW'(1);
      if (w_doPop)
        r_rdPtr <= r_rdPtr + AW'(1);
      if (w_doPush && !w_doPop)
        r_count <= r_count + (AW+1)'(1);
      else if (w_doPop && !w_doPush)
        r_count <= r_count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs op/rs/rt/rd_imm into 32-bit words, queues them, and issues one per cycle.
// Define LOAD_USE_STALL_EN to insert a bubble after a load whose destination the head reads.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_op,
  input  logic [7:0]       in_rs,
  input  logic [7:0]       in_rt,
  input  logic [7:0]       in_rd_imm,
  input  logic             Stall,
  output logic [31:0]      Instruction,
  output logic             InstrValid,
  output logic             Empty,
  output logic             Full,
  output logic [CNT_W-1:0] IssueCount
);

  logic [31:0]      r_instr;
  logic             r_instrValid;
  logic [CNT_W-1:0] r_issueCount;
  state_t           r_state;

  logic [31:0]      w_wdata;
  logic [31:0]      w_head;
  logic             w_push;
  logic             w_issue;
  logic             w_hazard;
  logic             w_bubbleDue;
  logic             w_almostEmpty;
  logic             w_nextEmpty;

`ifdef LOAD_USE_STALL_EN
  logic [7:0]       r_lastDest;
  logic             r_lastWasLoad;

  assign w_hazard = r_lastWasLoad && !Empty && readsReg(w_head, r_lastDest);
`else
  assign w_hazard = 1'b0;
`endif

  assign in_ready    = !Full && !Reset;
  assign w_push      = in_valid && in_ready;
  assign w_wdata     = packWord(in_op, in_rs, in_rt, in_rd_imm);
  assign w_bubbleDue = w_hazard && (r_state != ST_BUBBLE);
  assign w_issue     = !Stall && !Empty && !w_bubbleDue;
  assign w_nextEmpty = !w_push && (Empty || (w_almostEmpty && w_issue));

  assign Instruction = r_instr;
  assign InstrValid  = r_instrValid;
  assign IssueCount  = r_issueCount;

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .i_clk         (Clk),
    .i_reset       (Reset),
    .i_push        (w_push),
    .i_wdata       (w_wdata),
    .i_pop         (w_issue),
    .o_rdata       (w_head),
    .o_full        (Full),
    .o_empty       (Empty),
    .o_almostEmpty (w_almostEmpty)
  );

  // A stalled BUBBLE stays in BUBBLE so the dependent head still waits out one free cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_instr      <= NOP_WORD;
      r_instrValid <= 1'b0;
      r_issueCount <= '0;
      r_state      <= ST_IDLE;
    end else begin
      if (w_issue) begin
        r_instr      <= w_head;
        r_instrValid <= 1'b1;
        r_issueCount <= r_issueCount + CNT_W'(1);
      end else begin
        r_instr      <= NOP_WORD;
        r_instrValid <= 1'b0;
      end

      if (w_bubbleDue && !Stall)
        r_state <= ST_BUBBLE;
      else if (r_state == ST_BUBBLE && Stall)
        r_state <= ST_BUBBLE;
      else if (w_nextEmpty)
        r_state <= ST_IDLE;
      else
        r_state <= ST_ISSUE;
    end
  end

`ifdef LOAD_USE_STALL_EN
  // Any unstalled cycle without an issue sends a bubble downstream, which retires the hazard.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_lastDest    <= 8'h00;
      r_lastWasLoad <= 1'b0;
    end else if (w_issue) begin
      r_lastDest    <= w_head[RT_MSB:RT_LSB];
      r_lastWasLoad <= (w_head[OP_MSB:OP_LSB] == OP_LW);
    end else if (!Stall) begin
      r_lastWasLoad <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder; hazard expectations follow LOAD_USE_STALL_EN.
module tb_instr_encoder;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_op;
  logic [7:0]  in_rs;
  logic [7:0]  in_rt;
  logic [7:0]  in_rd_imm;
  logic        Stall;
  logic [31:0] Instruction;
  logic        InstrValid;
  logic        Empty;
  logic        Full;
  logic [15:0] IssueCount;

  int testCount = 0;
  int failCount = 0;

  instr_encoder dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_rs       (in_rs),
    .in_rt       (in_rt),
    .in_rd_imm   (in_rd_imm),
    .Stall       (Stall),
    .Instruction (Instruction),
    .InstrValid  (InstrValid),
    .Empty       (Empty),
    .Full        (Full),
    .IssueCount  (IssueCount)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] op, input logic [7:0] rs,
                               input logic [7:0] rt, input logic [7:0] rd);
    in_valid  = v;
    in_op     = op;
    in_rs     = rs;
    in_rt     = rt;
    in_rd_imm = rd;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    Reset = 1'b1;
    Stall = 1'b0;
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);

    // Reset state
    tick();
    checkOutput("rst_instr", Instruction, 32'hFF00_0000);
    checkOutput("rst_valid", {31'b0, InstrValid}, 32'd0);
    checkOutput("rst_count", {16'b0, IssueCount}, 32'd0);
    checkOutput("rst_empty", {31'b0, Empty}, 32'd1);
    checkOutput("rst_full", {31'b0, Full}, 32'd0);
    checkOutput("rst_ready", {31'b0, in_ready}, 32'd0);
    Reset = 1'b0;
    tick();

    // Single push, issued one edge later
    applyStimulus(1'b1, 8'h00, 8'h01, 8'h02, 8'h03);
    checkOutput("t1_ready", {31'b0, in_ready}, 32'd1);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    checkOutput("t1_latency_valid", {31'b0, InstrValid}, 32'd0);
    checkOutput("t1_not_empty", {31'b0, Empty}, 32'd0);
    tick();
    checkOutput("t1_instr", Instruction, 32'h0001_0203);
    checkOutput("t1_valid", {31'b0, InstrValid}, 32'd1);
    checkOutput("t1_count", {16'b0, IssueCount}, 32'd1);
    checkOutput("t1_empty", {31'b0, Empty}, 32'd1);
    tick();
    checkOutput("t1_nohold_instr", Instruction, 32'hFF00_0000);
    checkOutput("t1_nohold_valid", {31'b0, InstrValid}, 32'd0);

    // Fill under stall, refuse fifth, drain in order
    Stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 8'h00, 8'h10 + 8'(k), 8'h20 + 8'(k), 8'h30 + 8'(k));
      tick();
    end
    checkOutput("t2_full", {31'b0, Full}, 32'd1);
    checkOutput("t2_ready", {31'b0, in_ready}, 32'd0);
    applyStimulus(1'b1, 8'h00, 8'h77, 8'h77, 8'h77);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    checkOutput("t2_stall_valid", {31'b0, InstrValid}, 32'd0);
    checkOutput("t2_still_full", {31'b0, Full}, 32'd1);
    checkOutput("t2_stall_count", {16'b0, IssueCount}, 32'd1);
    Stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("t2_drain_instr", Instruction,
                  {8'h00, 8'h10 + 8'(k), 8'h20 + 8'(k), 8'h30 + 8'(k)});
      checkOutput("t2_drain_valid", {31'b0, InstrValid}, 32'd1);
      checkOutput("t2_drain_count", {16'b0, IssueCount}, 32'(2 + k));
    end
    checkOutput("t2_empty", {31'b0, Empty}, 32'd1);
    tick();
    checkOutput("t2_no_fifth", {31'b0, InstrValid}, 32'd0);

    // Load followed by a dependent R-type
    applyStimulus(1'b1, 8'h23, 8'h01, 8'h05, 8'h00);
    tick();
    applyStimulus(1'b1, 8'h00, 8'h05, 8'h02, 8'h06);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    checkOutput("t3_lw", Instruction, 32'h2301_0500);
    checkOutput("t3_lw_count", {16'b0, IssueCount}, 32'd6);
    tick();
`ifdef LOAD_USE_STALL_EN
    checkOutput("t3_bubble_instr", Instruction, 32'hFF00_0000);
    checkOutput("t3_bubble_valid", {31'b0, InstrValid}, 32'd0);
    tick();
`endif
    checkOutput("t3_rtype", Instruction, 32'h0005_0206);
    checkOutput("t3_rtype_valid", {31'b0, InstrValid}, 32'd1);
    checkOutput("t3_count", {16'b0, IssueCount}, 32'd7);
    tick();
    checkOutput("t3_idle", {31'b0, InstrValid}, 32'd0);

    // Reset with entries queued
    Stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 8'h00, 8'h50 + 8'(k), 8'h60, 8'h70);
      tick();
    end
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    checkOutput("t4_queued", {31'b0, Empty}, 32'd0);
    Reset = 1'b1;
    tick();
    checkOutput("t4_empty", {31'b0, Empty}, 32'd1);
    checkOutput("t4_valid", {31'b0, InstrValid}, 32'd0);
    checkOutput("t4_instr", Instruction, 32'hFF00_0000);
    checkOutput("t4_count", {16'b0, IssueCount}, 32'd0);
    Reset = 1'b0;
    Stall = 1'b0;
    tick();
    tick();
    checkOutput("t4_no_stale", {31'b0, InstrValid}, 32'd0);
    checkOutput("t4_still_empty", {31'b0, Empty}, 32'd1);

    // Full FIFO with simultaneous push attempt and issue
    Stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 8'h00, 8'h40 + 8'(k), 8'h41, 8'h42);
      tick();
    end
    Stall = 1'b0;
    applyStimulus(1'b1, 8'h00, 8'hAA, 8'hBB, 8'hCC);
    checkOutput("t6_ready_full", {31'b0, in_ready}, 32'd0);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    checkOutput("t6_issue0", Instruction, 32'h0040_4142);
    checkOutput("t6_not_full", {31'b0, Full}, 32'd0);
    checkOutput("t6_ready_after", {31'b0, in_ready}, 32'd1);
    for (int k = 1; k < 4; k++) begin
      tick();
      checkOutput("t6_issue", Instruction, {8'h00, 8'h40 + 8'(k), 8'h41, 8'h42});
    end
    tick();
    checkOutput("t6_refused", {31'b0, InstrValid}, 32'd0);
    checkOutput("t6_count", {16'b0, IssueCount}, 32'd4);

    // Stream to IssueCount = FFFF, then wrap
    applyStimulus(1'b1, 8'h00, 8'h01, 8'h02, 8'h03);
    for (int i = 0; i < 65531; i++)
      tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    checkOutput("t5_max", {16'b0, IssueCount}, 32'h0000_FFFF);
    applyStimulus(1'b1, 8'h00, 8'h09, 8'h08, 8'h07);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    checkOutput("t5_wrap", {16'b0, IssueCount}, 32'd0);
    checkOutput("t5_wrap_instr", Instruction, 32'h0009_0807);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
